// File: rtl/scan_sequencer_if.sv
// Control/status bundle between a scan controller and scan_sequencer.
// Carries pass_cnt only when SCAN_SEQUENCER_PASS_CNT_EN is defined.
interface scan_sequencer_if #(
  parameter int unsigned DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               loop;
  logic [7:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic [2:0]         sel;
  logic               en;
  logic               busy;
  logic               done;
`ifdef SCAN_SEQUENCER_PASS_CNT_EN
  logic [7:0]         pass_cnt;
`endif

  modport master (
    output start, stop, loop, mask, dwell,
`ifdef SCAN_SEQUENCER_PASS_CNT_EN
    input  pass_cnt,
`endif
    input  sel, en, busy, done
  );

  modport slave (
    input  start, stop, loop, mask, dwell,
`ifdef SCAN_SEQUENCER_PASS_CNT_EN
    output pass_cnt,
`endif
    output sel, en, busy, done
  );
endinterface

// File: rtl/scan_sequencer.sv
// Walks the enabled channels of an 8-way one-hot decoder, dwelling on each for a set time.
// Optional pass counter enabled by SCAN_SEQUENCER_PASS_CNT_EN.
module scan_sequencer #(
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned NCH     = 8
) (
  input  logic            clk,
  input  logic            rst,
  scan_sequencer_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e             state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               loop_q, loop_d;
  logic [7:0]         mask_q, mask_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] reload_q, reload_d;
  logic [DWELL_W-1:0] dwell_eff;
  logic [3:0]         first_new, first_cur, next_up;

  // Returns {found, index} of the lowest set bit.
  function automatic logic [3:0] lowest(input logic [7:0] m);
    logic [3:0] r;
    r = 4'b0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (m[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  assign dwell_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
  assign first_new = lowest(bus.mask);
  assign first_cur = lowest(mask_q);
  assign next_up   = lowest(mask_q & (8'hFE << sel_q));

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    en_d     = en_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    loop_d   = loop_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    case (state_q)
      StIdle: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
        if (bus.start) begin
          if (bus.mask != 8'h00) begin
            state_d  = StActive;
            mask_d   = bus.mask;
            loop_d   = bus.loop;
            reload_d = dwell_eff - DWELL_W'(1);
            cnt_d    = dwell_eff - DWELL_W'(1);
            sel_d    = first_new[2:0];
            en_d     = 1'b1;
            busy_d   = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StActive: begin
        en_d   = 1'b1;
        busy_d = 1'b1;
        if (bus.stop) begin
          state_d = StIdle;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (next_up[3]) begin
          sel_d = next_up[2:0];
          cnt_d = reload_q;
        end else if (loop_q) begin
          sel_d = first_cur[2:0];
          cnt_d = reload_q;
        end else begin
          state_d = StIdle;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      sel_q    <= 3'd0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      loop_q   <= 1'b0;
      mask_q   <= 8'h00;
      cnt_q    <= '0;
      reload_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      loop_q   <= loop_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
    end
  end

  assign bus.sel  = sel_q;
  assign bus.en   = en_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

`ifdef SCAN_SEQUENCER_PASS_CNT_EN
  logic [7:0] pass_q;
  logic       pass_clr, pass_inc;

  // A pass ends when the highest enabled channel expires without a stop.
  assign pass_clr = (state_q == StIdle) && bus.start && (bus.mask != 8'h00);
  assign pass_inc = (state_q == StActive) && !bus.stop && (cnt_q == '0) && !next_up[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_q <= 8'h00;
    end else if (pass_clr) begin
      pass_q <= 8'h00;
    end else if (pass_inc) begin
      pass_q <= pass_q + 8'd1;
    end
  end

  assign bus.pass_cnt = pass_q;
`endif

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: directed vector table, reset/pass sequences,
// and randomized traffic against a channel-list model.
module tb_scan_sequencer;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  scan_sequencer_if #(.DWELL_W(8)) bus ();

  scan_sequencer #(.DWELL_W(8), .NCH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       stop;
    logic       loop;
    logic [7:0] mask;
    logic [7:0] dwell;
    logic [2:0] sel;
    logic       en;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  // Model: list of enabled channels, position in it, cycles left on the current one.
  bit         m_active;
  int         m_list[$];
  int         m_idx;
  int         m_left;
  int         m_dwell;
  bit         m_loop;
  logic [2:0] e_sel;
  logic       e_en, e_busy, e_done;
  logic [7:0] e_pass;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input int s, input int e, input int b, input int d);
    check({tag, ".sel"}, int'(bus.sel), s);
    check({tag, ".en"}, int'(bus.en), e);
    check({tag, ".busy"}, int'(bus.busy), b);
    check({tag, ".done"}, int'(bus.done), d);
  endtask

  task automatic drive(input logic st, input logic sp, input logic lp, input logic [7:0] m,
                       input logic [7:0] d);
    bus.start = st;
    bus.stop  = sp;
    bus.loop  = lp;
    bus.mask  = m;
    bus.dwell = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_active = 0;
    m_list.delete();
    m_idx  = 0;
    m_left = 0;
    e_sel  = 3'd0;
    e_en   = 1'b0;
    e_busy = 1'b0;
    e_done = 1'b0;
    e_pass = 8'h00;
  endtask

  task automatic model_step(input logic st, input logic sp, input logic lp,
                            input logic [7:0] m, input logic [7:0] d);
    e_done = 1'b0;
    if (!m_active) begin
      if (st) begin
        if (m == 8'h00) begin
          e_done = 1'b1;
        end else begin
          m_list.delete();
          for (int i = 0; i < 8; i++) if (m[i]) m_list.push_back(i);
          m_dwell  = (d == 0) ? 1 : int'(d);
          m_loop   = lp;
          m_idx    = 0;
          m_left   = m_dwell;
          m_active = 1;
          e_pass   = 8'h00;
        end
      end
    end else if (sp) begin
      m_active = 0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_idx++;
        m_left = m_dwell;
        if (m_idx == m_list.size()) begin
          e_pass = e_pass + 8'd1;
          if (m_loop) m_idx = 0;
          else begin
            m_active = 0;
            e_done   = 1'b1;
          end
        end
      end
    end
    if (m_active) e_sel = 3'(m_list[m_idx]);
    e_en   = m_active;
    e_busy = m_active;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    repeat (2) tick();
    check_outs("reset", 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    check_outs("post_reset", 0, 0, 0, 0);

    //            start stop loop mask   dwell  sel en busy done
    vecs.push_back('{1, 0, 0, 8'hA5, 8'd2, 3'd0, 1, 1, 0});
    vecs.push_back('{0, 0, 0, 8'h00, 8'd0, 3'd0, 1, 1, 0});
    vecs.push_back('{1, 0, 1, 8'hFF, 8'd1, 3'd2, 1, 1, 0});  // start in ACTIVE ignored
    vecs.push_back('{0, 0, 0, 8'h00, 8'd0, 3'd2, 1, 1, 0});
    vecs.push_back('{0, 0, 0, 8'h00, 8'd0, 3'd5, 1, 1, 0});
    vecs.push_back('{0, 0, 0, 8'h00, 8'd0, 3'd5, 1, 1, 0});
    vecs.push_back('{0, 0, 0, 8'h00, 8'd0, 3'd7, 1, 1, 0});
    vecs.push_back('{0, 0, 0, 8'h00, 8'd0, 3'd7, 1, 1, 0});
    vecs.push_back('{0, 0, 0, 8'h00, 8'd0, 3'd7, 0, 0, 1});
    vecs.push_back('{0, 0, 0, 8'h00, 8'd0, 3'd7, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 8'd3, 3'd7, 0, 0, 1});  // empty mask: done only
    vecs.push_back('{0, 0, 0, 8'h00, 8'd0, 3'd7, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 8'h80, 8'd0, 3'd7, 1, 1, 0});  // dwell 0 acts as 1
    vecs.push_back('{0, 0, 0, 8'h00, 8'd0, 3'd7, 0, 0, 1});
    vecs.push_back('{0, 0, 0, 8'h00, 8'd0, 3'd7, 0, 0, 0});
    vecs.push_back('{0, 1, 0, 8'h00, 8'd0, 3'd7, 0, 0, 0});  // stop in IDLE ignored
    vecs.push_back('{1, 0, 1, 8'h12, 8'd1, 3'd1, 1, 1, 0});
    vecs.push_back('{0, 0, 0, 8'h00, 8'd0, 3'd4, 1, 1, 0});
    vecs.push_back('{0, 0, 0, 8'h00, 8'd0, 3'd1, 1, 1, 0});
    vecs.push_back('{0, 0, 0, 8'h00, 8'd0, 3'd4, 1, 1, 0});
    vecs.push_back('{0, 1, 0, 8'h00, 8'd0, 3'd4, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 8'h01, 8'd2, 3'd0, 1, 1, 0});
    vecs.push_back('{0, 0, 0, 8'h00, 8'd0, 3'd0, 1, 1, 0});
    vecs.push_back('{0, 1, 0, 8'h00, 8'd0, 3'd0, 0, 0, 0});  // stop beats final expiry

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].loop, vecs[i].mask, vecs[i].dwell);
      tick();
      check_outs($sformatf("vec%0d", i), int'(vecs[i].sel), int'(vecs[i].en),
                 int'(vecs[i].busy), int'(vecs[i].done));
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();

`ifdef SCAN_SEQUENCER_PASS_CNT_EN
    drive(1'b1, 1'b0, 1'b1, 8'h03, 8'd1);
    tick();
    check("pass_start", int'(bus.pass_cnt), 0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (10) tick();
    check("pass_ten", int'(bus.pass_cnt), 5);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    tick();
    check("pass_stop_hold", int'(bus.pass_cnt), 5);
    drive(1'b1, 1'b0, 1'b1, 8'h03, 8'd1);
    tick();
    check("pass_clear", int'(bus.pass_cnt), 0);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
`endif

    // Asynchronous reset in the middle of a scan.
    drive(1'b1, 1'b0, 1'b0, 8'hFF, 8'd3);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) tick();
    check_outs("pre_rst", 1, 1, 1, 0);
    #3;
    rst = 1'b1;
    #1;
    check_outs("async_rst", 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check_outs("rst_idle", 0, 0, 0, 0);

    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic       st, sp, lp;
      logic [7:0] m, d;
      st = ($urandom_range(0, 3) == 0);
      sp = ($urandom_range(0, 15) == 0);
      lp = $urandom_range(0, 1) != 0;
      case ($urandom_range(0, 7))
        0:       m = 8'h00;
        1:       m = 8'h01 << $urandom_range(0, 7);
        default: m = 8'($urandom_range(0, 255));
      endcase
      d = 8'($urandom_range(0, 4));
      drive(st, sp, lp, m, d);
      model_step(st, sp, lp, m, d);
      tick();
      check_outs($sformatf("rnd%0d", c), int'(e_sel), int'(e_en), int'(e_busy), int'(e_done));
      check("rnd_done_busy", int'(bus.done & bus.busy), 0);
`ifdef SCAN_SEQUENCER_PASS_CNT_EN
      check("rnd_pass", int'(bus.pass_cnt), int'(e_pass));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
